// File: rtl/memory_round_ctrl_pkg.sv
// Shared types and constants for the memory-game round sequencer.
package memory_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_ASK,
    ST_JUDGE1,
    ST_JUDGE2,
    ST_DONE
  } state_t;

  localparam logic [2:0] DS_SCORE = 3'd0;
  localparam logic [2:0] DS_SHOW  = 3'd1;
  localparam logic [2:0] DS_ASK   = 3'd2;
  localparam logic [2:0] DS_JUDGE = 3'd3;
  localparam logic [2:0] DS_DONE  = 3'd4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps at bits 8,6,5,4 (1-based) of a maximal-length 8-bit Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/memory_round_ctrl_if.sv
// Player keys and start in, scoring strobe and display status out.
interface memory_round_ctrl_if;
  logic       start;
  logic       key_yes_n;
  logic       key_no_n;
  logic       input_key;
  logic       exist;
  logic [2:0] display_state;
  logic [3:0] symbol;
  logic [6:0] round;

  modport master (
    output start, key_yes_n, key_no_n,
    input  input_key, exist, display_state, symbol, round
  );

  modport slave (
    input  start, key_yes_n, key_no_n,
    output input_key, exist, display_state, symbol, round
  );
endinterface

// File: rtl/memory_round_ctrl_key_debounce.sv
// Raw active-low key -> 2-flop sync -> stability counter -> one-cycle press pulse.
// A stable press pulses DEBOUNCE_CYCLES+2 cycles after the pin falls; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/memory_round_ctrl.sv
// Memory-game round sequencer: show symbol, take one answer, judge vs history, emit one strobe.
// Strobe lands 2 cycles after an accepted press pulse; presses outside ASK are dropped.
module memory_round_ctrl
  import memory_pkg::*;
#(
  parameter int SHOW_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MAX_ROUNDS      = 99
) (
  input logic                clk,
  input logic                reset,
  memory_round_ctrl_if.slave bus
);
  localparam int         TW    = $clog2(SHOW_CYCLES + 1);
  localparam logic [6:0] MAX_R = 7'(MAX_ROUNDS);

  state_t        state;
  logic [7:0]    lfsr;
  logic [15:0]   history;
  logic [TW-1:0] timer;
  logic          press_yes;
  logic          press_no;
  logic          one_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_yes (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_yes_n),
    .press (press_yes)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_no (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_no_n),
    .press (press_no)
  );

  // Simultaneous presses cancel out.
  assign one_press = press_yes ^ press_no;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      bus.input_key     <= 1'b1;
      bus.exist         <= 1'b0;
      bus.display_state <= DS_SCORE;
      bus.symbol        <= 4'd0;
      bus.round         <= 7'd0;
      history           <= 16'd0;
      timer             <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            history           <= 16'd0;
            bus.round         <= 7'd0;
            bus.symbol        <= lfsr[3:0];
            timer             <= TW'(SHOW_CYCLES - 1);
            state             <= ST_SHOW;
            bus.display_state <= DS_SHOW;
          end
        end
        ST_SHOW: begin
          if (timer == '0) begin
            state             <= ST_ASK;
            bus.display_state <= DS_ASK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_ASK: begin
          // exist settles a full cycle before the strobe falls.
          if (one_press) begin
            bus.exist         <= (press_yes == history[bus.symbol]);
            state             <= ST_JUDGE1;
            bus.display_state <= DS_JUDGE;
          end
        end
        ST_JUDGE1: begin
          bus.input_key <= 1'b0;
          state         <= ST_JUDGE2;
        end
        ST_JUDGE2: begin
          bus.input_key           <= 1'b1;
          history[bus.symbol]     <= 1'b1;
          if (bus.round != MAX_R) bus.round <= bus.round + 7'd1;
          if (bus.round >= MAX_R - 7'd1) begin
            state             <= ST_DONE;
            bus.display_state <= DS_DONE;
          end else begin
            bus.symbol        <= lfsr[3:0];
            timer             <= TW'(SHOW_CYCLES - 1);
            state             <= ST_SHOW;
            bus.display_state <= DS_SHOW;
          end
        end
        default: begin
          state             <= ST_IDLE;
          bus.display_state <= DS_SCORE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_round_ctrl.sv
// Directed bench for memory_round_ctrl with an exist scoreboard and an independent LFSR model.
module tb_memory_round_ctrl;
  localparam int SHOW = 4;
  localparam int DEB  = 3;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  memory_round_ctrl_if bus();

  memory_round_ctrl #(
    .SHOW_CYCLES     (SHOW),
    .DEBOUNCE_CYCLES (DEB),
    .MAX_ROUNDS      (MAXR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          exp_pulses = 0;
  int          rounds = 0;
  bit          sb_q[$];
  logic [15:0] hist;
  logic [3:0]  cur_sym;
  logic [7:0]  model;
  logic [7:0]  model_prev;
  logic [2:0]  prev_ds;
  logic        prev_low;

  // Reference LFSR: x^8 + x^6 + x^5 + x^4, shifting left.
  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model      <= 8'hA5;
      model_prev <= 8'hA5;
    end else begin
      model_prev <= model;
      model      <= step(model);
    end
  end

  // Monitor: symbol on SHOW entry, pulse width and exist against the scoreboard.
  initial begin
    prev_ds  = 3'd0;
    prev_low = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ds  = 3'd0;
        prev_low = 1'b0;
      end else begin
        if (bus.display_state == 3'd1 && prev_ds != 3'd1) begin
          chk("symbol", bus.symbol, model_prev[3:0]);
          cur_sym = model_prev[3:0];
        end
        if (bus.input_key === 1'b0) begin
          pulses++;
          chk("pulse_width", prev_low, 1'b0);
          chk("pulse_expected", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) chk("exist", bus.exist, sb_q.pop_front());
        end
        prev_low = ~bus.input_key;
        prev_ds  = bus.display_state;
      end
    end
  end

  task automatic wait_ds(input logic [2:0] code, input int budget);
    int n = 0;
    while (bus.display_state !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ds", bus.display_state, code);
  endtask

  // One answer; with force_rep, delay the press so the next symbol repeats a seen one.
  task automatic answer(input bit yes, input bit force_rep);
    logic [3:0]  s;
    logic [7:0]  v;
    logic [15:0] tgt;
    int          n;
    wait_ds(3'd2, 100);
    s = cur_sym;
    repeat (DEB + 3) @(negedge clk);
    if (force_rep) begin
      tgt = hist | (16'd1 << s);
      n = 0;
      while (n < 400) begin
        v = model;
        for (int i = 0; i < 7; i++) v = step(v);
        if (tgt[v[3:0]]) break;
        @(negedge clk);
        n++;
      end
    end
    sb_q.push_back(yes == hist[s]);
    exp_pulses++;
    if (yes) bus.key_yes_n = 1'b0;
    else     bus.key_no_n  = 1'b0;
    wait_ds(3'd3, 40);
    n = 0;
    while (bus.display_state == 3'd3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.key_yes_n = 1'b1;
    bus.key_no_n  = 1'b1;
    hist[s] = 1'b1;
    rounds++;
    chk("round", bus.round, rounds);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.key_yes_n = 1'b1;
    bus.key_no_n  = 1'b1;
    hist          = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_input_key", bus.input_key, 1'b1);
    chk("rst_exist", bus.exist, 1'b0);
    chk("rst_ds", bus.display_state, 3'd0);
    chk("rst_symbol", bus.symbol, 4'd0);
    chk("rst_round", bus.round, 7'd0);
    reset = 1'b0;
    @(negedge clk);

    // Game 1: new symbol, then a forced repeat answered yes, then noise.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    answer(1'b0, 1'b1);
    answer(1'b1, 1'b0);

    wait_ds(3'd2, 100);
    repeat (DEB + 3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      bus.key_no_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.key_no_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("noise_ds", bus.display_state, 3'd2);
    chk("noise_pulses", pulses, exp_pulses);
    bus.key_no_n  = 1'b0;
    bus.key_yes_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("both_ds", bus.display_state, 3'd2);
    chk("both_pulses", pulses, exp_pulses);
    bus.key_no_n  = 1'b1;
    bus.key_yes_n = 1'b1;
    answer(1'b0, 1'b0);
    wait_ds(3'd4, 20);
    chk("done_round", bus.round, 7'd3);
    chk("done_pulses", pulses, 3);

    bus.key_no_n = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    bus.key_no_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    chk("done_press_ds", bus.display_state, 3'd4);
    chk("done_press_pulses", pulses, exp_pulses);

    // Game 2: the press pulse falls inside SHOW and must be dropped.
    bus.key_no_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hist   = 16'd0;
    rounds = 0;
    chk("restart_round", bus.round, 7'd0);
    chk("restart_ds", bus.display_state, 3'd1);
    wait_ds(3'd2, 20);
    repeat (8) @(negedge clk);
    chk("show_press_ds", bus.display_state, 3'd2);
    chk("show_press_pulses", pulses, exp_pulses);
    bus.key_no_n = 1'b1;
    answer(1'b1, 1'b0);

    // Reset during the strobe-low cycle.
    wait_ds(3'd2, 100);
    repeat (DEB + 3) @(negedge clk);
    bus.key_no_n = 1'b0;
    wait_ds(3'd3, 40);
    @(posedge clk);
    #1;
    chk("judge_low", bus.input_key, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_input_key", bus.input_key, 1'b1);
    chk("arst_ds", bus.display_state, 3'd0);
    chk("arst_round", bus.round, 7'd0);
    chk("arst_symbol", bus.symbol, 4'd0);
    chk("arst_exist", bus.exist, 1'b0);
    bus.key_no_n = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("lfsr_seed_symbol", bus.symbol, 4'h5);
    hist   = 16'd0;
    rounds = 0;
    answer(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("final_pulses", pulses, exp_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
